des_round_sequencer: RTL and testbench

//  Iterative DES controller. Sequences a one-round DES datapath (L/R regs, f-function, C/D key regs)

---
 rtl/des_ctrl_pkg.sv | 17 +
 rtl/des_shift_sched.sv | 25 ++
 rtl/des_round_sequencer.sv | 107 ++++++++++
 tb/tb_des_round_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/des_ctrl_pkg.sv
// rtl/des_ctrl_pkg.sv - shared constants for the iterative DES round controller
package des_ctrl_pkg;

  typedef logic [2:0] ctrl_state_t;

  localparam int DES_ROUNDS = 16;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam ctrl_state_t ST_IDLE  = 3'd0;
  localparam ctrl_state_t ST_LOAD  = 3'd1;
  localparam ctrl_state_t ST_ROUND = 3'd2;
  localparam ctrl_state_t ST_FINAL = 3'd3;
  localparam ctrl_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/des_shift_sched.sv
// rtl/des_shift_sched.sv - per-round C/D rotate amount for encrypt and decrypt
module des_shift_sched #(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] i_round_idx,
  input  logic             i_decrypt,
  output logic [1:0]       o_shift_amt
);

  logic w_single;

  assign w_single = (i_round_idx == IDX_W'(0)) || (i_round_idx == IDX_W'(1)) ||
                    (i_round_idx == IDX_W'(8)) || (i_round_idx == IDX_W'(15));

  // Decrypt starts from the unrotated PC1 value, so its first round does not rotate.
  always_comb begin
    o_shift_amt = 2'd2;
    if (i_decrypt && (i_round_idx == IDX_W'(0))) begin
      o_shift_amt = 2'd0;
    end else if (w_single) begin
      o_shift_amt = 2'd1;
    end
  end

endmodule

// File: rtl/des_round_sequencer.sv
// rtl/des_round_sequencer.sv - load/16-round/final sequencer for a single-round DES datapath
module des_round_sequencer
  import des_ctrl_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS,
  parameter int IDX_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode_decrypt,
  input  logic             i_abort,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_result_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_dp_load,
  output logic             o_dp_round_en,
  output logic             o_dp_final,
  output logic [1:0]       o_ks_shift_amt,
  output logic             o_ks_shift_right,
  output logic [IDX_W-1:0] o_round_idx
);

  ctrl_state_t      r_state;
  logic [IDX_W-1:0] r_round;
  logic             r_mode;

  logic             w_advance;
  logic             w_in_round;
  logic             w_last;
  logic [1:0]       w_sched_amt;

  assign w_advance  = i_step_mode ? i_step : 1'b1;
  assign w_in_round = (r_state == ST_ROUND);
  assign w_last     = (r_round == IDX_W'(ROUNDS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_mode  <= MODE_ENC;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_mode  <= MODE_ENC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_mode  <= i_mode_decrypt;
            r_round <= '0;
          end
        end
        ST_LOAD: begin
          r_state <= ST_ROUND;
          r_round <= '0;
        end
        ST_ROUND: begin
          if (w_advance) begin
            if (w_last) begin
              r_state <= ST_FINAL;
              r_round <= '0;
            end else begin
              r_round <= r_round + IDX_W'(1);
            end
          end
        end
        ST_FINAL: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          // Mode clears here so ks_shift_right reads 0 whenever the controller is idle.
          if (i_result_ack) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_ENC;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_round <= '0;
          r_mode  <= MODE_ENC;
        end
      endcase
    end
  end

  des_shift_sched #(
    .IDX_W(IDX_W)
  ) u_shift_sched (
    .i_round_idx(r_round),
    .i_decrypt  (r_mode),
    .o_shift_amt(w_sched_amt)
  );

  assign o_busy           = (r_state == ST_LOAD) || w_in_round || (r_state == ST_FINAL);
  assign o_done           = (r_state == ST_DONE);
  assign o_dp_load        = (r_state == ST_LOAD);
  assign o_dp_final       = (r_state == ST_FINAL);
  assign o_dp_round_en    = w_in_round && w_advance;
  assign o_ks_shift_amt   = o_dp_round_en ? w_sched_amt : 2'd0;
  assign o_ks_shift_right = r_mode;
  assign o_round_idx      = w_in_round ? r_round : '0;

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb/tb_des_round_sequencer.sv - randomized self-checking bench for des_round_sequencer
module tb_des_round_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode_decrypt, abort, step_mode, step, result_ack;
  logic       busy, done, dp_load, dp_round_en, dp_final, ks_shift_right;
  logic [1:0] ks_shift_amt;
  logic [3:0] round_idx;

  int n_total = 0;
  int n_bad   = 0;
  int enc_tbl[16];
  int dec_tbl[16];

  des_round_sequencer #(.ROUNDS(16), .IDX_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode_decrypt(mode_decrypt),
    .i_abort(abort), .i_step_mode(step_mode), .i_step(step), .i_result_ack(result_ack),
    .o_busy(busy), .o_done(done), .o_dp_load(dp_load), .o_dp_round_en(dp_round_en),
    .o_dp_final(dp_final), .o_ks_shift_amt(ks_shift_amt), .o_ks_shift_right(ks_shift_right),
    .o_round_idx(round_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_load"}, dp_load, 0);
    check_eq({tag, "_round_en"}, dp_round_en, 0);
    check_eq({tag, "_final"}, dp_final, 0);
    check_eq({tag, "_idx"}, round_idx, 0);
    check_eq({tag, "_shamt"}, ks_shift_amt, 0);
    check_eq({tag, "_shright"}, ks_shift_right, 0);
  endtask

  // smode: 0 free-running, 1 single-step, 2 step_mode randomized every round cycle
  task automatic run_block(input bit dec, input int smode, input int ack_delay, input bit hold_start);
    int  k, guard, sum, exp_amt;
    bit  adv, sm;
    next_cycle();
    start = 1; mode_decrypt = dec; step = 1'($urandom % 2); result_ack = 1'($urandom % 2);
    @(negedge clk);
    check_eq("accept_busy", busy, 0);
    check_eq("accept_load", dp_load, 0);
    next_cycle();
    start = 0; mode_decrypt = ~dec; step = 1'($urandom % 2); result_ack = 1'($urandom % 2);
    @(negedge clk);
    check_eq("load_strobe", dp_load, 1);
    check_eq("load_busy", busy, 1);
    check_eq("load_round_en", dp_round_en, 0);
    k = 0; sum = 0; guard = 0;
    while (k < 16 && guard < 400) begin
      next_cycle();
      guard++;
      sm = (smode == 2) ? 1'($urandom % 2) : (smode == 1);
      step_mode = sm;
      step = ($urandom % 3 == 0);
      mode_decrypt = 1'($urandom % 2);
      result_ack = 1'($urandom % 2);
      start = 1'($urandom % 2);
      adv = sm ? step : 1'b1;
      @(negedge clk);
      check_eq("round_en", dp_round_en, adv);
      check_eq("round_idx", round_idx, k);
      check_eq("round_busy", busy, 1);
      check_eq("round_done", done, 0);
      if (adv) begin
        exp_amt = dec ? dec_tbl[k] : enc_tbl[k];
        check_eq("shift_amt", ks_shift_amt, exp_amt);
        check_eq("shift_right", ks_shift_right, dec);
        sum += int'(ks_shift_amt);
        k++;
      end
    end
    if (k < 16) check_eq("round_timeout", k, 16);
    check_eq("shift_sum", sum, dec ? 27 : 28);
    if (smode == 0) check_eq("round_cycles", guard, 16);
    next_cycle();
    step = 1'($urandom % 2); result_ack = 1'($urandom % 2); start = 1'($urandom % 2);
    @(negedge clk);
    check_eq("final_strobe", dp_final, 1);
    check_eq("final_busy", busy, 1);
    check_eq("final_idx", round_idx, 0);
    check_eq("final_done", done, 0);
    next_cycle();
    result_ack = 0; start = hold_start ? 1'b1 : 1'($urandom % 2);
    @(negedge clk);
    check_eq("done_rise", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_final", dp_final, 0);
    for (int i = 0; i < ack_delay; i++) begin
      next_cycle();
      result_ack = 0; step = 1'($urandom % 2);
      start = hold_start ? 1'b1 : 1'($urandom % 2);
      @(negedge clk);
      check_eq("done_hold", done, 1);
      check_eq("done_hold_load", dp_load, 0);
    end
    next_cycle();
    result_ack = 1; start = hold_start;
    @(negedge clk);
    check_eq("ack_cycle_done", done, 1);
    next_cycle();
    result_ack = 0; start = hold_start;
    @(negedge clk);
    check_idle("post_ack");
    if (hold_start) begin
      next_cycle();
      start = 0;
      @(negedge clk);
      check_eq("restart_load", dp_load, 1);
      check_eq("restart_busy", busy, 1);
      next_cycle();
      abort = 1;
      @(negedge clk);
      next_cycle();
      abort = 0;
      @(negedge clk);
      check_idle("restart_abort");
    end
  endtask

  task automatic run_abort(input int at_idx);
    int seen;
    next_cycle();
    start = 1; mode_decrypt = 1'($urandom % 2); step_mode = 0;
    @(negedge clk);
    next_cycle();
    start = 0;
    @(negedge clk);
    for (int k = 0; k <= at_idx; k++) begin
      next_cycle();
      if (k == at_idx) begin
        abort = 1; step = 1; result_ack = 1; start = 1;
      end
      @(negedge clk);
      check_eq("abort_pre_idx", round_idx, k);
    end
    next_cycle();
    abort = 0; step = 0; result_ack = 0; start = 0;
    @(negedge clk);
    check_idle("abort_next");
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      next_cycle();
      @(negedge clk);
      if (done || dp_final || busy) seen++;
    end
    check_eq("abort_quiet", seen, 0);
  endtask

  task automatic run_reset();
    next_cycle();
    start = 1; mode_decrypt = 1; step_mode = 0;
    @(negedge clk);
    next_cycle();
    start = 0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
    end
    check_eq("pre_rst_idx", round_idx, 5);
    #2 rst_n = 0;
    #1;
    check_idle("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_held");
    rst_n = 1;
    next_cycle();
    @(negedge clk);
    check_idle("rst_release");
  endtask

  initial begin
    enc_tbl = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    dec_tbl = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    rst_n = 0; start = 0; mode_decrypt = 0; abort = 0;
    step_mode = 0; step = 0; result_ack = 0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1;
    run_block(1'b0, 0, 3, 1'b0);
    run_block(1'b1, 0, 2, 1'b0);
    run_block(1'b0, 1, 1, 1'b0);
    run_block(1'b1, 1, 0, 1'b0);
    run_abort(7);
    run_block(1'b0, 0, 0, 1'b0);
    run_block(1'b1, 0, 50, 1'b1);
    run_reset();
    for (int i = 0; i < 6; i++) begin
      run_block(1'($urandom % 2), int'($urandom % 3), int'($urandom % 5), 1'b0);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
